tmds_encoder: RTL and testbench

//  Full DVI 1.0 TMDS 8b/10b encoder for one channel, with running DC-balance disparity.

---
 rtl/tmds_encoder_if.sv | 25 ++
 rtl/tmds_encoder.sv | 122 ++++++++++++
 tb/tb_tmds_encoder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel encoder.
// There is no handshake on this bus: the encoder takes one input set and
// produces one symbol on every clk25 edge, so there are no valid/ready signals.
interface tmds_encoder_if #(
  parameter int CNT_WIDTH = 5
);
  logic                        de;
  logic [7:0]                  data;
  logic                        c0;
  logic                        c1;
  logic [9:0]                  symbol;
  logic signed [CNT_WIDTH-1:0] disparity;

  // Pixel source side: drives video/control and receives the encoded symbol.
  modport master (
    output de, data, c0, c1,
    input  symbol, disparity
  );

  // Encoder side.
  modport slave (
    input  de, data, c0, c1,
    output symbol, disparity
  );
endinterface

// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b encoder for one channel, with running DC-balance disparity.
// Three register ranks: input capture, transition-minimised q_m, output symbol.
// An input captured at edge N is visible on symbol/disparity after edge N+2.
module tmds_encoder #(
  parameter int         CNT_WIDTH    = 5,
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input logic           clk25,
  input logic           reset,
  tmds_encoder_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] C_TWO   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] C_EIGHT = CNT_WIDTH'(8);

  // Input capture rank
  logic                 r_de0;
  logic [7:0]           r_data0;
  logic [1:0]           r_ctl0;
  // Stage-1 rank
  logic                 r_de1;
  logic [1:0]           r_ctl1;
  logic [8:0]           r_qm;
  // Output rank
  logic [9:0]           r_symbol;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [3:0]           w_n1d;
  logic                 w_use_xnor;
  logic [8:0]           w_qm;
  logic [3:0]           w_n1;
  logic [CNT_WIDTH-1:0] w_bal;
  logic                 w_cnt_zero;
  logic                 w_cnt_neg;
  logic [9:0]           w_sym_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  // Capture the pixel-side inputs; de and control travel with the data.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_de0   <= 1'b0;
      r_data0 <= '0;
      r_ctl0  <= 2'b00;
    end else begin
      r_de0   <= bus.de;
      r_data0 <= bus.data;
      r_ctl0  <= {bus.c1, bus.c0};
    end
  end

  // Stage 1: choose XOR or XNOR chaining to minimise transitions in q_m.
  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, r_data0[i]};
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !r_data0[0]);
    w_qm    = '0;
    w_qm[0] = r_data0[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_data0[i]) : (w_qm[i-1] ^ r_data0[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  // Register stage-1 results alongside the delayed de and control bits.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_de1  <= 1'b0;
      r_ctl1 <= 2'b00;
      r_qm   <= '0;
    end else begin
      r_de1  <= r_de0;
      r_ctl1 <= r_ctl0;
      r_qm   <= w_qm;
    end
  end

  // Stage 2: pick the inversion that pulls the running disparity toward zero.
  always_comb begin
    w_n1 = '0;
    for (int i = 0; i < 8; i++) w_n1 = w_n1 + {3'b000, r_qm[i]};
    // n1 - n0 = 2*n1 - 8, kept as two's complement in CNT_WIDTH bits
    w_bal      = CNT_WIDTH'({w_n1, 1'b0}) - C_EIGHT;
    w_cnt_zero = (r_cnt == '0);
    w_cnt_neg  = r_cnt[CNT_WIDTH-1];
    w_sym_next = RESET_SYMBOL;
    w_cnt_next = '0;
    if (!r_de1) begin
      // Blanking: fixed control code, disparity restarts from zero.
      case (r_ctl1)
        2'b00:   w_sym_next = 10'b1101010100;
        2'b01:   w_sym_next = 10'b0010101011;
        2'b10:   w_sym_next = 10'b0101010100;
        default: w_sym_next = 10'b1010101011;
      endcase
      w_cnt_next = '0;
    end else if (w_cnt_zero || (w_n1 == 4'd4)) begin
      w_sym_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_next = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
    end else if ((!w_cnt_neg && (w_n1 > 4'd4)) || (w_cnt_neg && (w_n1 < 4'd4))) begin
      w_sym_next = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_next = r_cnt + (r_qm[8] ? C_TWO : '0) - w_bal;
    end else begin
      w_sym_next = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_next = r_cnt - (r_qm[8] ? '0 : C_TWO) + w_bal;
    end
  end

  // Output register: symbol and the disparity after that symbol.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_symbol <= RESET_SYMBOL;
      r_cnt    <= '0;
    end else begin
      r_symbol <= w_sym_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign bus.symbol    = r_symbol;
  assign bus.disparity = r_cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed cases plus random traffic
// against a behavioural TMDS reference model with a two-cycle expected queue.
module tb_tmds_encoder;

  localparam int         CNT_WIDTH = 5;
  localparam logic [9:0] CTL00     = 10'b1101010100;

  // ---------------- clock / reset ----------------
  logic clk25 = 1'b0;
  logic reset = 1'b1;
  always #20 clk25 = ~clk25;

  tmds_encoder_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  tmds_encoder #(
    .CNT_WIDTH   (CNT_WIDTH),
    .RESET_SYMBOL(CTL00)
  ) dut (
    .clk25(clk25),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         exp_disp_q[$];
  logic [0:0] exp_de_q[$];
  logic [7:0] exp_data_q[$];
  int         model_cnt;
  logic [9:0] exp_sym;
  int         exp_disp;
  logic       exp_de;
  logic [7:0] exp_data;
  int         n_compared   = 0;
  int         n_mismatched = 0;

  logic [9:0] ctl_tab[4]   = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] zero_sym[4]  = '{10'b0100000000, 10'b1111111111, 10'b0100000000, 10'b1111111111};
  int         zero_disp[4] = '{-8, 2, -6, 4};

  // ---------------- reference model ----------------
  function automatic void ref_encode(input logic de, input logic [7:0] d, input logic [1:0] c,
                                     inout int cnt, output logic [9:0] sym);
    int ones, n1, bal, q8;
    logic xnor_path;
    logic [7:0] q;
    if (!de) begin
      sym = ctl_tab[c];
      cnt = 0;
      return;
    end
    ones      = $countones(d);
    xnor_path = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xnor_path ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8  = xnor_path ? 0 : 1;
    n1  = $countones(q);
    bal = n1 - (8 - n1);
    if (cnt == 0 || bal == 0) begin
      sym = {q8 == 0, q8 == 1, (q8 == 1) ? q : ~q};
      cnt = cnt + ((q8 == 1) ? bal : -bal);
    end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
      sym = {1'b1, q8 == 1, ~q};
      cnt = cnt + 2 * q8 - bal;
    end else begin
      sym = {1'b0, q8 == 1, q};
      cnt = cnt - 2 * (1 - q8) + bal;
    end
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] q, d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // After reset the pipeline holds two cleared (CTL00) entries.
  task automatic model_reset();
    exp_q.delete(); exp_disp_q.delete(); exp_de_q.delete(); exp_data_q.delete();
    repeat (2) begin
      exp_q.push_back(CTL00); exp_disp_q.push_back(0);
      exp_de_q.push_back(1'b0); exp_data_q.push_back(8'h00);
    end
    model_cnt = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic de, input logic [7:0] d, input logic [1:0] c);
    logic [9:0] s;
    ref_encode(de, d, c, model_cnt, s);
    exp_q.push_back(s); exp_disp_q.push_back(model_cnt);
    exp_de_q.push_back(de); exp_data_q.push_back(d);
    bus.de = de; bus.data = d; bus.c1 = c[1]; bus.c0 = c[0];
    @(posedge clk25); #1;
    exp_sym  = exp_q.pop_front();
    exp_disp = exp_disp_q.pop_front();
    exp_de   = exp_de_q.pop_front();
    exp_data = exp_data_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.de = 1'b0; bus.data = 8'h00; bus.c0 = 1'b0; bus.c1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk25); #1;
      n_compared++;
      if (bus.symbol !== CTL00 || bus.disparity !== 0) begin
        n_mismatched++;
        $display("FAIL reset_hold[%0d]: got sym=%b disp=%0d, want sym=%b disp=0", i, bus.symbol, bus.disparity, CTL00);
      end
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 8'($urandom), 2'b00);
      n_compared++;
      if (bus.symbol !== CTL00 || bus.disparity !== 0 || exp_sym !== CTL00) begin
        n_mismatched++;
        $display("FAIL reset_ctl00[%0d]: got sym=%b disp=%0d, want sym=%b disp=0", i, bus.symbol, bus.disparity, CTL00);
      end
    end
  endtask

  task automatic test_zero_data();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i >= 2, 8'h00, 2'($urandom));
      n_compared++;
      if (bus.symbol !== exp_sym || bus.disparity !== exp_disp) begin
        n_mismatched++;
        $display("FAIL zero_model[%0d]: got sym=%b disp=%0d, want sym=%b disp=%0d", i, bus.symbol, bus.disparity, exp_sym, exp_disp);
      end
      if (i >= 4) begin
        n_compared++;
        if (bus.symbol !== zero_sym[i-4] || bus.disparity !== zero_disp[i-4]) begin
          n_mismatched++;
          $display("FAIL zero_const[%0d]: got sym=%b disp=%0d, want sym=%b disp=%0d", i - 4, bus.symbol, bus.disparity, zero_sym[i-4], zero_disp[i-4]);
        end
      end
    end
  endtask

  task automatic test_ff_then_00();
    logic [7:0] seq_d[6]  = '{8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic       seq_de[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(seq_de[i], seq_d[i], 2'b00);
      n_compared++;
      if (bus.symbol !== exp_sym || bus.disparity !== exp_disp) begin
        n_mismatched++;
        $display("FAIL ff00_model[%0d]: got sym=%b disp=%0d, want sym=%b disp=%0d", i, bus.symbol, bus.disparity, exp_sym, exp_disp);
      end
      if (i == 4) begin
        n_compared++;
        if (bus.symbol !== 10'b1000000000 || bus.disparity !== -8) begin
          n_mismatched++;
          $display("FAIL ff_caseA: got sym=%b disp=%0d, want sym=1000000000 disp=-8", bus.symbol, bus.disparity);
        end
      end
      if (i == 5) begin
        n_compared++;
        if (bus.symbol !== 10'b1111111111 || bus.disparity !== 2) begin
          n_mismatched++;
          $display("FAIL 00_caseB: got sym=%b disp=%0d, want sym=1111111111 disp=2", bus.symbol, bus.disparity);
        end
      end
    end
  endtask

  task automatic test_ctrl_sweep();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 8'($urandom), (i < 4) ? 2'(i) : 2'b00);
      if (i >= 2) begin
        n_compared++;
        if (bus.symbol !== ctl_tab[i-2] || bus.disparity !== 0) begin
          n_mismatched++;
          $display("FAIL ctrl_code[%0d]: got sym=%b disp=%0d, want sym=%b disp=0", i - 2, bus.symbol, bus.disparity, ctl_tab[i-2]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic de = 1'b1;
    int   run_sum = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) de = ~de;
      drive_cycle(de, 8'($urandom), 2'($urandom));
      n_compared++;
      if (bus.symbol !== exp_sym || bus.disparity !== exp_disp) begin
        n_mismatched++;
        $display("FAIL rand_model[%0d]: got sym=%b disp=%0d, want sym=%b disp=%0d", i, bus.symbol, bus.disparity, exp_sym, exp_disp);
      end
      run_sum = exp_de ? run_sum + 2 * $countones(bus.symbol) - 10 : 0;
      n_compared++;
      if (bus.disparity !== run_sum || bus.disparity > 10 || bus.disparity < -10) begin
        n_mismatched++;
        $display("FAIL rand_balance[%0d]: got disp=%0d, want line ones-minus-zeros=%0d within +/-10", i, bus.disparity, run_sum);
      end
      if (exp_de) begin
        n_compared++;
        if (decode(bus.symbol) !== exp_data) begin
          n_mismatched++;
          $display("FAIL rand_decode[%0d]: got data=%h, want %h", i, decode(bus.symbol), exp_data);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 2'b00);
    reset = 1'b1;
    bus.de = 1'b1; bus.data = 8'($urandom);
    @(posedge clk25); #1;
    n_compared++;
    if (bus.symbol !== CTL00 || bus.disparity !== 0) begin
      n_mismatched++;
      $display("FAIL midreset_force: got sym=%b disp=%0d, want sym=%b disp=0", bus.symbol, bus.disparity, CTL00);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 8'($urandom), 2'($urandom));
      n_compared++;
      if (bus.symbol !== exp_sym || bus.disparity !== exp_disp) begin
        n_mismatched++;
        $display("FAIL midreset_model[%0d]: got sym=%b disp=%0d, want sym=%b disp=%0d", i, bus.symbol, bus.disparity, exp_sym, exp_disp);
      end
      if (i < 2) begin
        n_compared++;
        if (bus.symbol !== CTL00 || bus.disparity !== 0) begin
          n_mismatched++;
          $display("FAIL midreset_ctl00[%0d]: got sym=%b disp=%0d, want sym=%b disp=0", i, bus.symbol, bus.disparity, CTL00);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_data();
    test_ff_then_00();
    test_ctrl_sweep();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
